// File: rtl/noc_vchannel_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : noc_vchannel_buffer                                        |
// | Description : Per-VC first-word-fall-through input FIFOs feeding the VC  |
// |               output mux. Define NOC_VCHANNEL_BUFFER_PACKET_EN for       |
// |               per-VC store-and-forward; otherwise cut-through.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module noc_vchannel_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FLIT_WIDTH-1:0]          in_flit,
  input  logic                           in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
  output logic [CHANNELS-1:0]            out_last,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_vc
      logic [PW-1:0]       wp_q, wp_d, rp_q, rp_d;
      logic [FLIT_WIDTH:0] mem_q [DEPTH];
      logic                empty, full, wr_en, rd_en;

      // Extra wrap bit on each pointer separates full from empty.
      always_comb begin
        empty = (wp_q == rp_q);
        full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
        wr_en = in_valid[c] && in_ready[c];
        rd_en = out_valid[c] && out_ready[c];
        wp_d  = wp_q + PW'(wr_en);
        rp_d  = rp_q + PW'(rd_en);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wp_q <= '0;
          rp_q <= '0;
        end else begin
          wp_q <= wp_d;
          rp_q <= rp_d;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp_q[AW-1:0]] <= {in_flit, in_last};
      end

      assign in_ready[c]                          = rst_n && !full;
      assign out_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = mem_q[rp_q[AW-1:0]][FLIT_WIDTH:1];
      assign out_last[c]                          = mem_q[rp_q[AW-1:0]][0];

`ifdef NOC_VCHANNEL_BUFFER_PACKET_EN
      localparam int CW = $clog2(DEPTH + 1);
      logic [CW-1:0] pc_q, pc_d;
      logic          pkt_in, pkt_out;

      // Count of complete packets held; a head is only offered once its tail is in.
      always_comb begin
        pkt_in  = wr_en && in_last;
        pkt_out = rd_en && out_last[c];
        pc_d    = pc_q;
        if (pkt_in && !pkt_out)      pc_d = pc_q + CW'(1);
        else if (!pkt_in && pkt_out) pc_d = pc_q - CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
      end

      assign out_valid[c] = !empty && (pc_q != '0);

      // A full FIFO without a complete packet can never drain.
      a_no_oversize_pkt : assert property (@(posedge clk) disable iff (!rst_n)
        !(full && (pc_q == '0)));
`else
      assign out_valid[c] = !empty;
`endif
    end
  endgenerate

endmodule
`default_nettype wire
